// File: rtl/cvxif_coproc_hub_if.sv
// Bundle between the core, the coprocessor channels and cvxif_coproc_hub.
// The hub connects through the slave modport; the core/coprocessor side uses master.
interface cvxif_coproc_hub_if #(
    parameter int NR_COPROC = 2,
    parameter int ID_W      = 3,
    parameter int DATA_W    = 64
);
    // Every valid/ready pair follows the same rule: a transfer happens on the rising edge
    // where both are high, and a raised valid keeps its payload steady until that edge.
    logic                          flush_i;
    logic                          issue_valid_i;
    logic                          issue_ready_o;
    logic [31:0]                   issue_instr_i;
    logic [ID_W-1:0]               issue_id_i;
    logic                          issue_accept_o;
    logic [NR_COPROC-1:0]          cp_issue_valid_o;
    logic [NR_COPROC-1:0]          cp_issue_ready_i;
    logic [31:0]                   cp_issue_instr_o;
    logic [ID_W-1:0]               cp_issue_id_o;
    logic [NR_COPROC-1:0]          cp_result_valid_i;
    logic [NR_COPROC-1:0]          cp_result_ready_o;
    logic [NR_COPROC*ID_W-1:0]     cp_result_id_i;
    logic [NR_COPROC*DATA_W-1:0]   cp_result_data_i;
    logic                          result_valid_o;
    logic                          result_ready_i;
    logic [ID_W-1:0]               result_id_o;
    logic [DATA_W-1:0]             result_data_o;
    logic                          idle_o;
    logic [NR_COPROC*32-1:0]       perf_issue_cnt_o;
    logic [31:0]                   perf_stall_cnt_o;

    modport slave (
        input  flush_i, issue_valid_i, issue_instr_i, issue_id_i, cp_issue_ready_i,
               cp_result_valid_i, cp_result_id_i, cp_result_data_i, result_ready_i,
        output issue_ready_o, issue_accept_o, cp_issue_valid_o, cp_issue_instr_o, cp_issue_id_o,
               cp_result_ready_o, result_valid_o, result_id_o, result_data_o, idle_o,
               perf_issue_cnt_o, perf_stall_cnt_o
    );

    modport master (
        output flush_i, issue_valid_i, issue_instr_i, issue_id_i, cp_issue_ready_i,
               cp_result_valid_i, cp_result_id_i, cp_result_data_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, cp_issue_valid_o, cp_issue_instr_o, cp_issue_id_o,
               cp_result_ready_o, result_valid_o, result_id_o, result_data_o, idle_o,
               perf_issue_cnt_o, perf_stall_cnt_o
    );
endinterface

// File: rtl/cvxif_coproc_hub.sv
// Routes core issues to coprocessor channels by funct3, tracks busy IDs and merges results
// round-robin into one output register. Define CVXIF_HUB_PERF_EN to build the perf counters.
module cvxif_coproc_hub #(
    parameter int NR_COPROC      = 2,
    parameter int ID_W           = 3,
    parameter int DATA_W         = 64,
    parameter int RES_FIFO_DEPTH = 4
) (
    input logic               clk_i,
    input logic               rst_ni,
    cvxif_coproc_hub_if.slave bus
);
    localparam int NR_IDS = 2 ** ID_W;
    localparam int CW     = (NR_COPROC > 1) ? $clog2(NR_COPROC) : 1;
    localparam int AW     = $clog2(RES_FIFO_DEPTH);

    logic [NR_IDS-1:0]    busy_q, busy_d;
    logic [2:0]           ch;
    logic                 reject, stall, sel_ready, issue_hs;
    logic [NR_COPROC-1:0] issue_sel;

    logic [DATA_W-1:0]    fifo_data [NR_COPROC][RES_FIFO_DEPTH];
    logic [ID_W-1:0]      fifo_id   [NR_COPROC][RES_FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q  [NR_COPROC];
    logic [AW-1:0]        rd_ptr_q  [NR_COPROC];
    logic [AW:0]          cnt_q     [NR_COPROC];
    logic [NR_COPROC-1:0] fifo_full, fifo_empty, res_ready, push, pop;

    logic                 out_valid_q;
    logic [ID_W-1:0]      out_id_q;
    logic [DATA_W-1:0]    out_data_q;
    logic [CW-1:0]        rr_ptr_q, winner, rr_next;
    logic [CW:0]          idx_sum;
    logic                 found, load, res_hs;

    // Issue routing: a busy ID or a flush blocks everything, a reject is acknowledged unclaimed.
    always_comb begin
        ch        = bus.issue_instr_i[14:12];
        reject    = ({29'd0, ch} >= 32'(NR_COPROC));
        stall     = busy_q[bus.issue_id_i] | bus.flush_i;
        sel_ready = 1'b0;
        issue_sel = '0;
        for (int c = 0; c < NR_COPROC; c++) begin
            if (ch == 3'(c)) begin
                sel_ready    = bus.cp_issue_ready_i[c];
                issue_sel[c] = 1'b1;
            end
        end
    end

    assign bus.issue_ready_o    = !stall && (reject || sel_ready);
    assign bus.issue_accept_o   = !stall && !reject;
    assign bus.cp_issue_valid_o = (!stall && !reject && bus.issue_valid_i) ? issue_sel : '0;
    assign bus.cp_issue_instr_o = bus.issue_instr_i;
    assign bus.cp_issue_id_o    = bus.issue_id_i;
    assign issue_hs = bus.issue_valid_i && bus.issue_ready_o && bus.issue_accept_o;

    // Results for IDs no longer busy (killed by flush) are always taken and dropped.
    always_comb begin
        for (int c = 0; c < NR_COPROC; c++) begin
            fifo_full[c]  = (cnt_q[c] == (AW+1)'(RES_FIFO_DEPTH));
            fifo_empty[c] = (cnt_q[c] == '0);
            res_ready[c]  = !fifo_full[c] || !busy_q[bus.cp_result_id_i[c*ID_W +: ID_W]];
            push[c]       = bus.cp_result_valid_i[c] && res_ready[c]
                            && busy_q[bus.cp_result_id_i[c*ID_W +: ID_W]];
        end
    end

    assign bus.cp_result_ready_o = res_ready;

    always_comb begin
        load    = !out_valid_q || bus.result_ready_i;
        found   = 1'b0;
        winner  = '0;
        idx_sum = '0;
        for (int i = 0; i < NR_COPROC; i++) begin
            idx_sum = {1'b0, rr_ptr_q} + (CW+1)'(i);
            if (idx_sum >= (CW+1)'(NR_COPROC)) idx_sum = idx_sum - (CW+1)'(NR_COPROC);
            if (!found && !fifo_empty[idx_sum[CW-1:0]]) begin
                found  = 1'b1;
                winner = idx_sum[CW-1:0];
            end
        end
        rr_next = (32'(winner) + 32'd1 >= 32'(NR_COPROC)) ? '0 : winner + 1'b1;
        pop     = '0;
        if (load && found) pop[winner] = 1'b1;
    end

    assign res_hs = out_valid_q && bus.result_ready_i;

    // No bypass: a retiring ID clears only at the edge, so a same-cycle reissue still stalls.
    always_comb begin
        busy_d = busy_q;
        if (issue_hs) busy_d[bus.issue_id_i] = 1'b1;
        if (res_hs)   busy_d[out_id_q]       = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            rr_ptr_q    <= '0;
            for (int c = 0; c < NR_COPROC; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else if (bus.flush_i) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < NR_COPROC; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int c = 0; c < NR_COPROC; c++) begin
                if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
                if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
                cnt_q[c] <= cnt_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
            end
            if (load) begin
                out_valid_q <= found;
                if (found) begin
                    out_id_q   <= fifo_id[winner][rd_ptr_q[winner]];
                    out_data_q <= fifo_data[winner][rd_ptr_q[winner]];
                    rr_ptr_q   <= rr_next;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NR_COPROC; c++) begin
            if (push[c]) begin
                fifo_data[c][wr_ptr_q[c]] <= bus.cp_result_data_i[c*DATA_W +: DATA_W];
                fifo_id[c][wr_ptr_q[c]]   <= bus.cp_result_id_i[c*ID_W +: ID_W];
            end
        end
    end

    assign bus.result_valid_o = out_valid_q;
    assign bus.result_id_o    = out_id_q;
    assign bus.result_data_o  = out_data_q;
    assign bus.idle_o         = !(|busy_q) && (&fifo_empty) && !out_valid_q;

`ifdef CVXIF_HUB_PERF_EN
    logic [31:0]             issue_cnt_q [NR_COPROC];
    logic [31:0]             stall_cnt_q;
    logic [NR_COPROC*32-1:0] issue_cnt_flat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NR_COPROC; c++) issue_cnt_q[c] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int c = 0; c < NR_COPROC; c++) begin
                if (issue_hs && issue_sel[c]) issue_cnt_q[c] <= issue_cnt_q[c] + 32'd1;
            end
            if (bus.issue_valid_i && !bus.issue_ready_o) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    always_comb begin
        issue_cnt_flat = '0;
        for (int c = 0; c < NR_COPROC; c++) issue_cnt_flat[c*32 +: 32] = issue_cnt_q[c];
    end

    assign bus.perf_issue_cnt_o = issue_cnt_flat;
    assign bus.perf_stall_cnt_o = stall_cnt_q;
`else
    assign bus.perf_issue_cnt_o = '0;
    assign bus.perf_stall_cnt_o = '0;
`endif
endmodule

// File: doc/cvxif_coproc_hub.md
CVXIF_COPROC_HUB -- requirements
Module: cvxif_coproc_hub

Interface
REQ-001 SHALL have parameter NR_COPROC, default 2, number of attached coprocessor channels (1..8).
REQ-002 SHALL have parameter ID_W, default 3, instruction ID width; scoreboard depth is 2**ID_W.
REQ-003 SHALL have parameter DATA_W, default 64, result data width.
REQ-004 SHALL have parameter RES_FIFO_DEPTH, default 4, per-channel result FIFO depth (power of 2, >=2).
REQ-005 SHALL have ports as follows (C = NR_COPROC):
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- flush_i  in  1  kill all outstanding instructions.
- issue_valid_i  in  1  core issue request.
- issue_ready_o  out  1  issue accepted this cycle.
- issue_instr_i  in  32  instruction.
- issue_id_i  in  ID_W  instruction ID.
- issue_accept_o  out  1  instruction claimed by a channel.
- cp_issue_valid_o  out  C  per-channel issue.
- cp_issue_ready_i  in  C  per-channel ready.
- cp_issue_instr_o  out  32  shared instruction.
- cp_issue_id_o  out  ID_W  shared ID.
- cp_result_valid_i  in  C  per-channel result valid.
- cp_result_ready_o  out  C  per-channel result ready.
- cp_result_id_i  in  C*ID_W  result IDs.
- cp_result_data_i  in  C*DATA_W  result data.
- result_valid_o  out  1  result to core.
- result_ready_i  in  1  core accepts result.
- result_id_o  out  ID_W  result ID.
- result_data_o  out  DATA_W  result data.
- idle_o  out  1  nothing outstanding or buffered.
- perf_issue_cnt_o  out  C*32  per-channel issue counters.
- perf_stall_cnt_o  out  32  issue stall cycles.
REQ-006 SHALL use one clock, clk_i; reset rst_ni is asynchronous, active-low.

Function
REQ-007 SHALL select channel ch = issue_instr_i[14:12]; ch >= NR_COPROC is a reject.
REQ-008 SHALL stall (issue_ready_o=0, all cp_issue_valid_o=0) when busy[issue_id_i]=1 or flush_i=1.
REQ-009 SHALL, without stall: for a reject drive issue_ready_o=1, issue_accept_o=0; otherwise cp_issue_valid_o[ch]=issue_valid_i, issue_ready_o=cp_issue_ready_i[ch], issue_accept_o=1; all combinational.
REQ-010 SHALL set busy[issue_id_i] on the clock after an accepted issue handshake.
REQ-011 SHALL drive cp_result_ready_o[c] = !fifo_full[c] or !busy[cp_result_id_i[c]]; results with non-busy ID are consumed and discarded.
REQ-012 SHALL push a busy-ID result into channel c FIFO on handshake; FIFO pointers wrap modulo RES_FIFO_DEPTH.
REQ-013 SHALL hold one output register; it loads when empty or consumed the same cycle, via round-robin across non-empty FIFOs starting at rr_ptr; rr_ptr becomes winner+1 modulo NR_COPROC.
REQ-014 SHALL give minimum latency of 1 cycle from FIFO push to result_valid_o.
REQ-015 SHALL hold result_valid_o/id/data stable until result_ready_i=1.
REQ-016 SHALL clear busy[result_id_o] on the clock after result handshake; issue of that ID the same cycle still stalls (no bypass).
REQ-017 SHALL, on flush_i=1, clear all busy bits, empty all FIFOs and the output register at the next clock; flush overrides simultaneous push, pop and issue.
REQ-018 SHALL drive idle_o=1 iff no busy bit set, all FIFOs empty and output register empty.

Reset
REQ-019 SHALL on rst_ni=0 clear busy bits, FIFOs, output register (result_valid_o=0, id/data=0), rr_ptr=0, counters=0; idle_o=1.

Configuration
REQ-020 SHALL, with CVXIF_HUB_PERF_EN defined, count accepted issues per channel and cycles with issue_valid_i=1 and issue_ready_o=0, 32-bit wrapping, cleared only by reset.
REQ-021 SHALL, without CVXIF_HUB_PERF_EN, tie perf_issue_cnt_o and perf_stall_cnt_o to 0 with no counter flops.

Verification
REQ-022 Issue funct3=1, id=2, cp_issue_ready_i=2'b10 -> cp_issue_valid_o=2'b10, accept=1; busy[2]=1 next cycle; idle_o=0.
REQ-023 Issue funct3=5 with NR_COPROC=2 -> issue_ready_o=1, issue_accept_o=0, no cp_issue_valid_o, no busy set.
REQ-024 Busy id=3 reissued -> issue_ready_o=0 until the id=3 result handshake, then accepted the following cycle.
REQ-025 Both channels push results (id 0, id 1) same cycle, result_ready_i=1 -> outputs id 0 then id 1 in consecutive cycles; rr_ptr=0 after.
REQ-026 Fill channel 0 FIFO to 4 with result_ready_i=0 -> cp_result_ready_o[0]=0 for busy IDs; stale id still accepted and dropped.
REQ-027 flush_i with 3 outstanding and 2 buffered -> next cycle result_valid_o=0, idle_o=1; later result of killed id discarded.
